// File: rtl/bootrom_arbiter.sv
// Two-master round-robin arbiter in front of the single-ported boot ROM.
// M0 is instruction fetch (classic or incrementing burst), M1 is data/debug.
// A one-clock idle gap separates owners so the ROM's chip-select edge detector
// restarts its address counter; stalled cycles are aborted after TIMEOUT clocks.
module bootrom_arbiter #(
  parameter int unsigned WID     = 128,
  parameter int unsigned AWID    = 18,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // Master 0
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [AWID-1:0] m0_adr_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [WID-1:0]  m0_dat_o,
  // Master 1
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [AWID-1:0] m1_adr_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [WID-1:0]  m1_dat_o,
  // ROM slave
  output logic            s_cs_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [AWID-1:0] s_adr_o,
  input  logic            s_ack_i,
  input  logic [WID-1:0]  s_dat_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;
  localparam logic [TmoW-1:0] TmoThr = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StGap} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [WID-1:0]  m0_dat_q, m0_dat_d;
  logic [WID-1:0]  m1_dat_q, m1_dat_d;

  logic req0, req1;
  logic own0, own1, own;
  logic cur_stb;
  logic stall, tmo_hit;
  logic ack0, ack1;
  logic [TmoW-1:0] tmo_inc;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign own0    = (state_q == StOwn0);
  assign own1    = (state_q == StOwn1);
  assign own     = own0 | own1;
  assign cur_stb = own1 ? m1_stb_i : m0_stb_i;
  assign stall   = own & cur_stb & ~s_ack_i;
  // An ack in the threshold cycle suppresses the timeout.
  assign tmo_hit = stall & (tmo_q == TmoThr);
  // Acks only reach a master that still holds its cycle; late acks are dropped.
  assign ack0    = own0 & s_ack_i & m0_cyc_i;
  assign ack1    = own1 & s_ack_i & m1_cyc_i;
  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + TmoW'(1);

  assign m0_dat_o = m0_dat_q;
  assign m1_dat_o = m1_dat_q;

  // State, round-robin pointer, stall counter and read-data holding registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      tmo_q    <= '0;
      m0_dat_q <= '0;
      m1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      m0_dat_q <= m0_dat_d;
      m1_dat_q <= m1_dat_d;
    end
  end

  // Next-state: arbitration, ownership release, timeout abort, data capture.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    tmo_d    = '0;
    m0_dat_d = ack0 ? s_dat_i : m0_dat_q;
    m1_dat_d = ack1 ? s_dat_i : m1_dat_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i || tmo_hit) begin
          state_d = StGap;
          last_d  = 1'b0;
        end else if (stall) begin
          tmo_d = tmo_inc;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i || tmo_hit) begin
          state_d = StGap;
          last_d  = 1'b1;
        end else if (stall) begin
          tmo_d = tmo_inc;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: slave bus muxed from the owner, responses routed back to it.
  always_comb begin
    s_cs_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = 3'b000;
    s_adr_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (own0) begin
      s_cs_o   = m0_cyc_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_cti_o  = m0_cti_i;
      s_adr_o  = m0_adr_i;
      m0_ack_o = ack0;
      m0_err_o = tmo_hit & m0_cyc_i;
    end else if (own1) begin
      s_cs_o   = m1_cyc_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_cti_o  = m1_cti_i;
      s_adr_o  = m1_adr_i;
      m1_ack_o = ack1;
      m1_err_o = tmo_hit & m1_cyc_i;
    end
  end

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed bench for bootrom_arbiter: the bench plays the ROM by driving
// s_ack_i/s_dat_i, pushes each expected read word to a per-master queue, and a
// monitor pops and compares when the master's ack appears.
module tb_bootrom_arbiter;

  localparam int unsigned WID     = 128;
  localparam int unsigned AWID    = 18;
  localparam int unsigned TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [2:0]      m0_cti_i, m1_cti_i;
  logic [AWID-1:0] m0_adr_i, m1_adr_i;
  logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [WID-1:0]  m0_dat_o, m1_dat_o;
  logic            s_cs_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [2:0]      s_cti_o;
  logic [AWID-1:0] s_adr_o;
  logic [WID-1:0]  s_dat_i;

  int n_cmp = 0;
  int n_err = 0;
  logic [WID-1:0] q0[$];
  logic [WID-1:0] q1[$];
  bit pend0 = 1'b0;
  bit pend1 = 1'b0;

  always #5 clk = ~clk;

  bootrom_arbiter #(.WID(WID), .AWID(AWID), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_adr_i(m0_adr_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_adr_i(m1_adr_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cs_o(s_cs_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_adr_o(s_adr_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  function automatic logic [WID-1:0] rom_word(input int unsigned idx);
    logic [31:0] w;
    w = 32'hC0DE_0000 + idx;
    return {4{w}};
  endfunction

  task automatic check(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic cyc, input logic [2:0] cti, input logic [AWID-1:0] adr);
    m0_cyc_i = cyc; m0_stb_i = cyc; m0_cti_i = cti; m0_adr_i = adr;
  endtask

  task automatic drive1(input logic cyc, input logic [2:0] cti, input logic [AWID-1:0] adr);
    m1_cyc_i = cyc; m1_stb_i = cyc; m1_cti_i = cti; m1_adr_i = adr;
  endtask

  task automatic rom_ack(input logic ack, input logic [WID-1:0] dat);
    s_ack_i = ack; s_dat_i = dat;
  endtask

  // Scoreboard: read data is registered, so compare one cycle after the ack.
  always @(negedge clk) begin
    if (pend0) check("m0_dat", m0_dat_o, q0.pop_front());
    if (pend1) check("m1_dat", m1_dat_o, q1.pop_front());
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (m0_ack_o) begin
      n_cmp++;
      assert (q0.size() != 0) else begin
        n_err++;
        $error("FAIL m0_ack_unexpected: observed ack=1 expected ack=0");
      end
      pend0 = (q0.size() != 0);
    end
    if (m1_ack_o) begin
      n_cmp++;
      assert (q1.size() != 0) else begin
        n_err++;
        $error("FAIL m1_ack_unexpected: observed ack=1 expected ack=0");
      end
      pend1 = (q1.size() != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int err_at;
    rst_ni = 1'b0;
    drive0(1'b0, 3'b000, '0);
    drive1(1'b0, 3'b000, '0);
    rom_ack(1'b0, '0);
    #1;
    // Reset values
    check("rst_s_bus", {s_cs_o, s_cyc_o, s_stb_o, s_cti_o, s_adr_o}, '0);
    check("rst_m_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, '0);
    check("rst_m0_dat", m0_dat_o, '0);
    check("rst_m1_dat", m1_dat_o, '0);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();

    // 1: M0 classic read, ack 3 clocks after chip select rises
    drive0(1'b1, 3'b000, 18'h00010);
    tick();
    @(negedge clk);
    check("t1_cs", s_cs_o, 1'b1);
    check("t1_adr", s_adr_o, 18'h00010);
    repeat (3) tick();
    rom_ack(1'b1, rom_word(1));
    q0.push_back(rom_word(1));
    @(negedge clk);
    check("t1_ack0", m0_ack_o, 1'b1);
    check("t1_ack1", m1_ack_o, 1'b0);
    tick();
    rom_ack(1'b0, '0);
    drive0(1'b0, 3'b000, '0);
    @(negedge clk);
    check("t1_ack_pulse", m0_ack_o, 1'b0);
    check("t1_dat", m0_dat_o, rom_word(1));
    repeat (3) tick();

    // 2: simultaneous requests after reset, M0 first, then alternation
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    drive0(1'b1, 3'b000, 18'h00020);
    drive1(1'b1, 3'b000, 18'h00040);
    tick();
    @(negedge clk);
    check("t2_first_m0", s_adr_o, 18'h00020);
    tick();
    rom_ack(1'b1, rom_word(2));
    q0.push_back(rom_word(2));
    @(negedge clk);
    check("t2_m1_no_ack", m1_ack_o, 1'b0);
    tick();
    rom_ack(1'b0, '0);
    drive0(1'b0, 3'b000, '0);
    @(negedge clk);
    check("t2_cs_drop", s_cs_o, 1'b0);
    tick();
    drive0(1'b1, 3'b000, 18'h00030);
    @(negedge clk);
    check("t2_gap_cs", s_cs_o, 1'b0);
    tick();
    @(negedge clk);
    check("t2_idle_cs", s_cs_o, 1'b0);
    tick();
    @(negedge clk);
    check("t2_rr_m1", s_adr_o, 18'h00040);
    check("t2_rr_m1_cs", s_cs_o, 1'b1);
    tick();
    rom_ack(1'b1, rom_word(4));
    q1.push_back(rom_word(4));
    @(negedge clk);
    check("t2_m0_no_ack", m0_ack_o, 1'b0);
    tick();
    rom_ack(1'b0, '0);
    drive1(1'b0, 3'b000, '0);
    repeat (3) tick();
    @(negedge clk);
    check("t2_rr_m0", s_adr_o, 18'h00030);
    tick();
    rom_ack(1'b1, rom_word(3));
    q0.push_back(rom_word(3));
    tick();
    rom_ack(1'b0, '0);
    drive0(1'b0, 3'b000, '0);
    repeat (3) tick();

    // 3: M0 4-beat incrementing burst holds the ROM while M1 waits
    drive0(1'b1, 3'b010, 18'h00100);
    tick();
    drive1(1'b1, 3'b000, 18'h00200);
    @(negedge clk);
    check("t3_cti", s_cti_o, 3'b010);
    for (int b = 0; b < 4; b++) begin
      tick();
      drive0(1'b1, (b == 3) ? 3'b111 : 3'b010, 18'h00100 + AWID'(16 * b));
      rom_ack(1'b1, rom_word(16 + b));
      q0.push_back(rom_word(16 + b));
      @(negedge clk);
      check("t3_beat_adr", s_adr_o, 18'h00100 + AWID'(16 * b));
      check("t3_m1_wait", m1_ack_o, 1'b0);
    end
    tick();
    rom_ack(1'b0, '0);
    drive0(1'b0, 3'b000, '0);
    @(negedge clk);
    check("t3_drop_cs", s_cs_o, 1'b0);
    tick();
    @(negedge clk);
    check("t3_gap_cs", s_cs_o, 1'b0);
    tick();
    @(negedge clk);
    check("t3_idle_cs", s_cs_o, 1'b0);
    tick();
    @(negedge clk);
    check("t3_m1_after", s_adr_o, 18'h00200);
    tick();
    rom_ack(1'b1, rom_word(32));
    q1.push_back(rom_word(32));
    tick();
    rom_ack(1'b0, '0);
    drive1(1'b0, 3'b000, '0);
    repeat (3) tick();

    // 4: ROM never acks, M1 times out in clock 64 of ownership
    drive1(1'b1, 3'b000, 18'h00300);
    tick();
    err_at = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (m1_err_o) begin
        err_at = k;
        break;
      end
      tick();
    end
    check("t4_err_cycle", err_at, 64);
    check("t4_m0_err", m0_err_o, 1'b0);
    tick();
    @(negedge clk);
    check("t4_cs_after", s_cs_o, 1'b0);
    check("t4_err_pulse", m1_err_o, 1'b0);
    drive1(1'b0, 3'b000, '0);
    repeat (3) tick();

    // 4b: ack landing on the threshold clock wins over the timeout
    drive0(1'b1, 3'b000, 18'h00400);
    tick();
    repeat (63) tick();
    rom_ack(1'b1, rom_word(64));
    q0.push_back(rom_word(64));
    @(negedge clk);
    check("t4b_no_err", m0_err_o, 1'b0);
    check("t4b_ack", m0_ack_o, 1'b1);
    tick();
    rom_ack(1'b0, '0);
    drive0(1'b0, 3'b000, '0);
    repeat (3) tick();

    // 5: reset mid-cycle clears outputs at once, M1 granted one clock after release
    drive0(1'b1, 3'b000, 18'h00500);
    tick();
    @(negedge clk);
    check("t5_cs_own", s_cs_o, 1'b1);
    tick();
    rst_ni = 1'b0;
    #1;
    check("t5_cs_async", s_cs_o, 1'b0);
    s_ack_i = 1'b1;
    #1;
    check("t5_ack_blocked", m0_ack_o, 1'b0);
    check("t5_dat_cleared", m0_dat_o, '0);
    s_ack_i = 1'b0;
    drive0(1'b0, 3'b000, '0);
    drive1(1'b1, 3'b000, 18'h00600);
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    @(negedge clk);
    check("t5_m1_cs", s_cs_o, 1'b1);
    check("t5_m1_adr", s_adr_o, 18'h00600);
    tick();
    rom_ack(1'b1, rom_word(96));
    q1.push_back(rom_word(96));
    tick();
    rom_ack(1'b0, '0);
    drive1(1'b0, 3'b000, '0);
    repeat (3) tick();

    // 6: M0 abandons the cycle, the late ROM ack reaches nobody
    drive0(1'b1, 3'b000, 18'h00700);
    tick();
    @(negedge clk);
    check("t6_cs", s_cs_o, 1'b1);
    tick();
    drive0(1'b0, 3'b000, '0);
    rom_ack(1'b1, rom_word(112));
    @(negedge clk);
    check("t6_late_m0", m0_ack_o, 1'b0);
    check("t6_late_m1", m1_ack_o, 1'b0);
    tick();
    @(negedge clk);
    check("t6_gap_m0", m0_ack_o, 1'b0);
    check("t6_gap_m1", m1_ack_o, 1'b0);
    check("t6_dat_hold", m0_dat_o, '0);
    tick();
    rom_ack(1'b0, '0);
    repeat (3) tick();

    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
